// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes the operands LSB first,
// and the carry is recirculated through a flop. The result is registered with a done pulse.

module FullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] sSh_q, sSh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             faS, faC;

    FullAdder uFullAdder (
        .a_i (aSh_q[0]),
        .b_i (bSh_q[0]),
        .c_i (carry_q),
        .s_o (faS),
        .c_o (faC)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sSh_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sSh_q   <= sSh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sSh_d   = sSh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    aSh_d   = a_i;
                    bSh_d   = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sSh_d   = {faS, sSh_q[WIDTH-1:1]};
                aSh_d   = aSh_q >> 1;
                bSh_d   = bSh_q >> 1;
                carry_d = faC;
                cnt_d   = cnt_q + CW'(1);
                // The last bit goes straight into the result, so there is no extra cycle.
                if (cnt_q == LAST) begin
                    sum_d   = {faS, sSh_q[WIDTH-1:1]};
                    cout_d  = faC;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a cycle-count reference model checked on every
// cycle, plus directed cases with literal expectations and a randomized phase.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstN = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int  compared = 0;
    int  mismatched = 0;
    int  cycle = 0;
    bit  checking = 1'b0;

    // Reference model: phase counts the edges since the accept (-1 means idle).
    int           phase = -1;
    logic [W:0]   pending = '0;
    logic [W-1:0] expSum = '0;
    logic         expCout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rstN),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phase   = -1;
            expSum  = '0;
            expCout = 1'b0;
        end else if (phase < 0) begin
            if (start) begin
                phase   = 0;
                pending = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            end
        end else begin
            phase++;
            if (phase == W) {expCout, expSum} = pending;
            if (phase == W + 1) phase = -1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy", busy, (phase >= 0 && phase < W));
            checkOutput("done", done, (phase == W));
            checkOutput("sum", sum, expSum);
            checkOutput("cout", cout, expCout);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        @(negedge clk);
        a = av; b = bv; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic runAdd(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic c, input logic [W-1:0] s, input logic co);
        applyStimulus(av, bv, c);
        waitDone(name);
        checkOutput({name, "_sum"}, sum, s);
        checkOutput({name, "_cout"}, cout, co);
    endtask

    initial begin
        int busyCnt, doneCnt, doneAt, rise1, rise2, dones;
        logic prevBusy;

        // Asynchronous reset with no clock edge involved
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        checking = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        // Basic add, with busy/done timing
        applyStimulus(8'h3C, 8'h0F, 1'b0);
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int i = 0; i < 12; i++) begin
            busyCnt += int'(busy);
            doneCnt += int'(done);
            if (done && doneAt < 0) doneAt = i;
            if (done) checkOutput("model_sum", expSum, 8'h4B);
            @(negedge clk);
        end
        checkOutput("basic_busycnt", busyCnt, W);
        checkOutput("basic_donecnt", doneCnt, 1);
        checkOutput("basic_doneat", doneAt, W);
        checkOutput("basic_sum", sum, 8'h4B);
        checkOutput("basic_cout", cout, 0);

        // Full carry ripple
        runAdd("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        runAdd("ripple2", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

        // Start while busy and during done is ignored
        applyStimulus(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignore");
        checkOutput("ignore_sum", sum, 8'h30);
        checkOutput("ignore_cout", cout, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busyCnt = 0; doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            busyCnt += int'(busy);
            doneCnt += int'(done);
            @(negedge clk);
        end
        checkOutput("ignore_nobusy", busyCnt, 0);
        checkOutput("ignore_nodone", doneCnt, 0);

        // Back-to-back with start held high
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        prevBusy = 1'b0; rise1 = -1; rise2 = -1; dones = 0;
        for (int i = 0; i < 40 && dones < 2; i++) begin
            @(negedge clk);
            if (busy && !prevBusy) begin
                if (rise1 < 0) rise1 = cycle; else rise2 = cycle;
            end
            prevBusy = busy;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    checkOutput("b2b_sum1", sum, 8'h03);
                    checkOutput("b2b_cout1", cout, 0);
                    a = 8'h80; b = 8'h80;
                end else begin
                    checkOutput("b2b_sum2", sum, 8'h00);
                    checkOutput("b2b_cout2", cout, 1);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b_dones", dones, 2);
        checkOutput("b2b_spacing", rise2 - rise1, W + 2);
        repeat (3) @(negedge clk);

        // Reset mid-operation abandons the add
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_sum", sum, 0);
        checkOutput("midrst_cout", cout, 0);
        doneCnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            doneCnt += int'(done);
        end
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            doneCnt += int'(done);
        end
        checkOutput("midrst_nodone", doneCnt, 0);
        runAdd("postrst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Random phase: the model checks every cycle
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
